// File: rtl/reg_file_mp.sv
// Architectural register file plus rename alias table: per-slot operand lookup with
// intra-bundle rename forwarding and same-cycle commit bypass, in-order commit/rename update.

module reg_file_mp_rd #(
   parameter int XLEN         = 32,
   parameter int REG_LOG      = 5,
   parameter int ROB_SIZE_LOG = 4,
   parameter int NUM_COMMIT   = 2
) (
   input  logic [REG_LOG-1:0]                        regid,
   input  logic                                      fwd_hit,
   input  logic [ROB_SIZE_LOG-1:0]                   fwd_tag,
   input  logic                                      busy,
   input  logic [ROB_SIZE_LOG-1:0]                   tag,
   input  logic [XLEN-1:0]                           value,
   input  logic [NUM_COMMIT-1:0]                     commit_valid,
   input  logic [NUM_COMMIT-1:0][XLEN-1:0]           commit_value,
   input  logic [NUM_COMMIT-1:0][ROB_SIZE_LOG-1:0]   commit_robid,
   output logic                                      ready,
   output logic [XLEN-1:0]                           v,
   output logic [ROB_SIZE_LOG-1:0]                   q
);
   always_comb begin
      ready = 1'b1;
      v     = '0;
      q     = '0;
      if (regid != '0) begin
         if (fwd_hit) begin
            ready = 1'b0;
            q     = fwd_tag;
         end else if (busy) begin
            ready = 1'b0;
            q     = tag;
            // ascending scan so the highest matching port wins
            for (int c = 0; c < NUM_COMMIT; c++) begin
               if (commit_valid[c] && commit_robid[c] == tag) begin
                  ready = 1'b1;
                  v     = commit_value[c];
                  q     = '0;
               end
            end
         end else begin
            v = value;
         end
      end
   end
endmodule

module reg_file_mp #(
   parameter int XLEN         = 32,
   parameter int REG_LOG      = 5,
   parameter int ROB_SIZE_LOG = 4,
   parameter int NUM_SLOTS    = 2,
   parameter int NUM_COMMIT   = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  rdy,
   input  logic [NUM_SLOTS*REG_LOG-1:0]          rs1,
   input  logic [NUM_SLOTS*REG_LOG-1:0]          rs2,
   output logic [NUM_SLOTS*XLEN-1:0]             vj,
   output logic [NUM_SLOTS*XLEN-1:0]             vk,
   output logic [NUM_SLOTS*ROB_SIZE_LOG-1:0]     qj,
   output logic [NUM_SLOTS*ROB_SIZE_LOG-1:0]     qk,
   output logic [NUM_SLOTS-1:0]                  rj,
   output logic [NUM_SLOTS-1:0]                  rk,
   input  logic [NUM_COMMIT-1:0]                 commit_valid,
   input  logic [NUM_COMMIT*REG_LOG-1:0]         commit_regid,
   input  logic [NUM_COMMIT*XLEN-1:0]            commit_value,
   input  logic [NUM_COMMIT*ROB_SIZE_LOG-1:0]    commit_robid,
   input  logic [NUM_SLOTS-1:0]                  rename_valid,
   input  logic [NUM_SLOTS*REG_LOG-1:0]          rename_regid,
   input  logic [NUM_SLOTS*ROB_SIZE_LOG-1:0]     rename_robid,
   input  logic                                  pred_fail_flag,
   output logic [REG_LOG:0]                      busy_cnt
);
   localparam int NREG = 1 << REG_LOG;

   logic [NREG-1:0][XLEN-1:0]          value_q, value_d;
   logic [NREG-1:0][ROB_SIZE_LOG-1:0]  tag_q, tag_d;
   logic [NREG-1:0]                    busy_q, busy_d;

   logic [NUM_SLOTS-1:0][REG_LOG-1:0]        rs1_a, rs2_a, ren_reg_a;
   logic [NUM_SLOTS-1:0][ROB_SIZE_LOG-1:0]   ren_rob_a, qj_a, qk_a;
   logic [NUM_SLOTS-1:0][XLEN-1:0]           vj_a, vk_a;
   logic [NUM_COMMIT-1:0][REG_LOG-1:0]       cm_reg_a;
   logic [NUM_COMMIT-1:0][XLEN-1:0]          cm_val_a;
   logic [NUM_COMMIT-1:0][ROB_SIZE_LOG-1:0]  cm_rob_a;

   logic [NUM_SLOTS-1:0]                     fwd1_hit, fwd2_hit;
   logic [NUM_SLOTS-1:0][ROB_SIZE_LOG-1:0]   fwd1_tag, fwd2_tag;

   assign rs1_a     = rs1;
   assign rs2_a     = rs2;
   assign ren_reg_a = rename_regid;
   assign ren_rob_a = rename_robid;
   assign cm_reg_a  = commit_regid;
   assign cm_val_a  = commit_value;
   assign cm_rob_a  = commit_robid;
   assign vj        = vj_a;
   assign vk        = vk_a;
   assign qj        = qj_a;
   assign qk        = qk_a;

   // Only strictly older slots forward; the youngest matching one is the live mapping.
   always_comb begin
      fwd1_hit = '0;
      fwd2_hit = '0;
      fwd1_tag = '0;
      fwd2_tag = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         for (int j = 0; j < s; j++) begin
            if (rename_valid[j] && !pred_fail_flag && ren_reg_a[j] != '0) begin
               if (ren_reg_a[j] == rs1_a[s]) begin
                  fwd1_hit[s] = 1'b1;
                  fwd1_tag[s] = ren_rob_a[j];
               end
               if (ren_reg_a[j] == rs2_a[s]) begin
                  fwd2_hit[s] = 1'b1;
                  fwd2_tag[s] = ren_rob_a[j];
               end
            end
         end
      end
   end

   for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      reg_file_mp_rd #(.XLEN(XLEN), .REG_LOG(REG_LOG), .ROB_SIZE_LOG(ROB_SIZE_LOG),
                       .NUM_COMMIT(NUM_COMMIT)) u_rd_j (
         .regid(rs1_a[s]), .fwd_hit(fwd1_hit[s]), .fwd_tag(fwd1_tag[s]),
         .busy(busy_q[rs1_a[s]]), .tag(tag_q[rs1_a[s]]), .value(value_q[rs1_a[s]]),
         .commit_valid(commit_valid), .commit_value(cm_val_a), .commit_robid(cm_rob_a),
         .ready(rj[s]), .v(vj_a[s]), .q(qj_a[s])
      );
      reg_file_mp_rd #(.XLEN(XLEN), .REG_LOG(REG_LOG), .ROB_SIZE_LOG(ROB_SIZE_LOG),
                       .NUM_COMMIT(NUM_COMMIT)) u_rd_k (
         .regid(rs2_a[s]), .fwd_hit(fwd2_hit[s]), .fwd_tag(fwd2_tag[s]),
         .busy(busy_q[rs2_a[s]]), .tag(tag_q[rs2_a[s]]), .value(value_q[rs2_a[s]]),
         .commit_valid(commit_valid), .commit_value(cm_val_a), .commit_robid(cm_rob_a),
         .ready(rk[s]), .v(vk_a[s]), .q(qk_a[s])
      );
   end

   // Commits first, then flush or renames, so a rename overrides a same-cycle clear.
   always_comb begin
      value_d = value_q;
      tag_d   = tag_q;
      busy_d  = busy_q;
      for (int c = 0; c < NUM_COMMIT; c++) begin
         if (commit_valid[c] && cm_reg_a[c] != '0) begin
            value_d[cm_reg_a[c]] = cm_val_a[c];
            if (busy_q[cm_reg_a[c]] && tag_q[cm_reg_a[c]] == cm_rob_a[c]) begin
               busy_d[cm_reg_a[c]] = 1'b0;
               tag_d[cm_reg_a[c]]  = '0;
            end
         end
      end
      if (pred_fail_flag) begin
         busy_d = '0;
         tag_d  = '0;
      end else begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (rename_valid[s] && ren_reg_a[s] != '0) begin
               busy_d[ren_reg_a[s]] = 1'b1;
               tag_d[ren_reg_a[s]]  = ren_rob_a[s];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
         tag_q   <= '0;
         busy_q  <= '0;
      end else if (rdy) begin
         value_q <= value_d;
         tag_q   <= tag_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < NREG; i++) busy_cnt = busy_cnt + (REG_LOG+1)'(busy_q[i]);
   end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a table of per-cycle stimulus with expected pre-edge
// read results, followed by an asynchronous-reset sequence.

module tb_reg_file_mp;
   logic        clk, rst_n, rdy, pred_fail_flag;
   logic [9:0]  rs1, rs2, commit_regid, rename_regid;
   logic [63:0] vj, vk, commit_value;
   logic [7:0]  qj, qk, commit_robid, rename_robid;
   logic [1:0]  rj, rk, commit_valid, rename_valid;
   logic [5:0]  busy_cnt;

   int n_total = 0;
   int n_pass  = 0;

   reg_file_mp dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .rs1(rs1), .rs2(rs2),
      .vj(vj), .vk(vk), .qj(qj), .qk(qk), .rj(rj), .rk(rk),
      .commit_valid(commit_valid), .commit_regid(commit_regid),
      .commit_value(commit_value), .commit_robid(commit_robid),
      .rename_valid(rename_valid), .rename_regid(rename_regid), .rename_robid(rename_robid),
      .pred_fail_flag(pred_fail_flag), .busy_cnt(busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed pairs are {slot1, slot0} / {port1, port0}.
   typedef struct {
      logic        rdy;
      logic [9:0]  rs1, rs2;
      logic [1:0]  cv;
      logic [9:0]  creg;
      logic [63:0] cval;
      logic [7:0]  crob;
      logic [1:0]  rv;
      logic [9:0]  rreg;
      logic [7:0]  rrob;
      logic        flush;
      logic [1:0]  erj;
      logic [7:0]  eqj;
      logic [63:0] evj;
      logic [1:0]  erk;
      logic [7:0]  eqk;
      logic [63:0] evk;
      logic [5:0]  ecnt;
   } vec_t;

   vec_t vt[18];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic idle_inputs();
      rdy = 1'b1; pred_fail_flag = 1'b0;
      rs1 = '0; rs2 = '0;
      commit_valid = '0; commit_regid = '0; commit_value = '0; commit_robid = '0;
      rename_valid = '0; rename_regid = '0; rename_robid = '0;
   endtask

   task automatic check_vec(input int i, input vec_t t);
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("v%0d rj%0d", i, s), 64'(rj[s]), 64'(t.erj[s]));
         if (t.erj[s]) chk($sformatf("v%0d vj%0d", i, s), 64'(vj[s*32 +: 32]), 64'(t.evj[s*32 +: 32]));
         else          chk($sformatf("v%0d qj%0d", i, s), 64'(qj[s*4 +: 4]), 64'(t.eqj[s*4 +: 4]));
         chk($sformatf("v%0d rk%0d", i, s), 64'(rk[s]), 64'(t.erk[s]));
         if (t.erk[s]) chk($sformatf("v%0d vk%0d", i, s), 64'(vk[s*32 +: 32]), 64'(t.evk[s*32 +: 32]));
         else          chk($sformatf("v%0d qk%0d", i, s), 64'(qk[s*4 +: 4]), 64'(t.eqk[s*4 +: 4]));
      end
      chk($sformatf("v%0d busy_cnt", i), 64'(busy_cnt), 64'(t.ecnt));
   endtask

   localparam logic [31:0] DB = 32'hDEADBEEF;

   initial begin
      //        rdy rs1              rs2              cv     creg             cval              crob           rv     rreg             rrob           fl erj    eqj            evj              erk    eqk            evk              cnt
      vt[0]  = '{1, {5'd0, 5'd5},   {5'd0, 5'd0},   2'b00, 10'd0,           64'd0,            8'd0,          2'b00, 10'd0,           8'd0,          0, 2'b11, 8'd0,          64'd0,           2'b11, 8'd0,          64'd0,           6'd0};
      // rename x5->rob3; slot1 sees it, slot0 does not
      vt[1]  = '{1, {5'd5, 5'd5},   {5'd0, 5'd0},   2'b00, 10'd0,           64'd0,            8'd0,          2'b01, {5'd0, 5'd5},    {4'd0, 4'd3},  0, 2'b01, {4'd3, 4'd0},  64'd0,           2'b11, 8'd0,          64'd0,           6'd0};
      vt[2]  = '{1, {5'd5, 5'd5},   {5'd0, 5'd0},   2'b00, 10'd0,           64'd0,            8'd0,          2'b00, 10'd0,           8'd0,          0, 2'b00, {4'd3, 4'd3},  64'd0,           2'b11, 8'd0,          64'd0,           6'd1};
      // commit rob3 bypasses to readers the same cycle
      vt[3]  = '{1, {5'd5, 5'd5},   {5'd0, 5'd0},   2'b01, {5'd0, 5'd5},    {32'd0, DB},      {4'd0, 4'd3},  2'b00, 10'd0,           8'd0,          0, 2'b11, 8'd0,          {DB, DB},        2'b11, 8'd0,          64'd0,           6'd1};
      vt[4]  = '{1, {5'd5, 5'd5},   {5'd0, 5'd0},   2'b00, 10'd0,           64'd0,            8'd0,          2'b00, 10'd0,           8'd0,          0, 2'b11, 8'd0,          {DB, DB},        2'b11, 8'd0,          64'd0,           6'd0};
      // intra-bundle x7->rob9
      vt[5]  = '{1, {5'd7, 5'd7},   {5'd5, 5'd5},   2'b00, 10'd0,           64'd0,            8'd0,          2'b01, {5'd0, 5'd7},    {4'd0, 4'd9},  0, 2'b01, {4'd9, 4'd0},  64'd0,           2'b11, 8'd0,          {DB, DB},        6'd0};
      vt[6]  = '{1, {5'd4, 5'd7},   {5'd0, 5'd0},   2'b00, 10'd0,           64'd0,            8'd0,          2'b01, {5'd0, 5'd4},    {4'd0, 4'd2},  0, 2'b00, {4'd2, 4'd9},  64'd0,           2'b11, 8'd0,          64'd0,           6'd1};
      // re-rename x4->rob6 on slot1; own-slot rename invisible
      vt[7]  = '{1, {5'd4, 5'd4},   {5'd0, 5'd0},   2'b00, 10'd0,           64'd0,            8'd0,          2'b10, {5'd4, 5'd0},    {4'd6, 4'd0},  0, 2'b00, {4'd2, 4'd2},  64'd0,           2'b11, 8'd0,          64'd0,           6'd2};
      // stale commit rob2 to x4
      vt[8]  = '{1, {5'd4, 5'd4},   {5'd0, 5'd0},   2'b01, {5'd0, 5'd4},    {32'd0, 32'd11},  {4'd0, 4'd2},  2'b00, 10'd0,           8'd0,          0, 2'b00, {4'd6, 4'd6},  64'd0,           2'b11, 8'd0,          64'd0,           6'd2};
      vt[9]  = '{1, {5'd4, 5'd4},   {5'd7, 5'd7},   2'b00, 10'd0,           64'd0,            8'd0,          2'b00, 10'd0,           8'd0,          0, 2'b00, {4'd6, 4'd6},  64'd0,           2'b00, {4'd9, 4'd9},  64'd0,           6'd2};
      // commit rob6 on port1 + rename x4->rob1
      vt[10] = '{1, {5'd4, 5'd4},   {5'd0, 5'd0},   2'b10, {5'd4, 5'd0},    {32'd22, 32'd0},  {4'd6, 4'd0},  2'b01, {5'd0, 5'd4},    {4'd0, 4'd1},  0, 2'b01, {4'd1, 4'd0},  {32'd0, 32'd22}, 2'b11, 8'd0,          64'd0,           6'd2};
      vt[11] = '{1, {5'd4, 5'd4},   {5'd0, 5'd0},   2'b00, 10'd0,           64'd0,            8'd0,          2'b00, 10'd0,           8'd0,          0, 2'b00, {4'd1, 4'd1},  64'd0,           2'b11, 8'd0,          64'd0,           6'd2};
      // dual commit to x8
      vt[12] = '{1, {5'd8, 5'd8},   {5'd4, 5'd7},   2'b11, {5'd8, 5'd8},    {32'd2, 32'd1},   {4'd14, 4'd15},2'b00, 10'd0,           8'd0,          0, 2'b11, 8'd0,          64'd0,           2'b00, {4'd1, 4'd9},  64'd0,           6'd2};
      // flush + rename x9 + commit x10
      vt[13] = '{1, {5'd9, 5'd8},   {5'd4, 5'd4},   2'b01, {5'd0, 5'd10},   {32'd0, 32'h55},  {4'd0, 4'd12}, 2'b01, {5'd0, 5'd9},    {4'd0, 4'd4},  1, 2'b11, 8'd0,          {32'd0, 32'd2},  2'b00, {4'd1, 4'd1},  64'd0,           6'd2};
      vt[14] = '{1, {5'd10, 5'd9},  {5'd4, 5'd7},   2'b00, 10'd0,           64'd0,            8'd0,          2'b00, 10'd0,           8'd0,          0, 2'b11, 8'd0,          {32'h55, 32'd0}, 2'b11, 8'd0,          {32'd22, 32'd0}, 6'd0};
      // rdy=0: reads live, no state change
      vt[15] = '{0, {5'd11, 5'd10}, {5'd0, 5'd0},   2'b01, {5'd0, 5'd10},   {32'd0, 32'h77},  8'd0,          2'b11, {5'd0, 5'd11},   {4'd7, 4'd5},  0, 2'b01, {4'd5, 4'd0},  {32'd0, 32'h55}, 2'b11, 8'd0,          64'd0,           6'd0};
      // x0 commit/rename must be ignored
      vt[16] = '{1, {5'd11, 5'd10}, {5'd0, 5'd0},   2'b01, {5'd0, 5'd0},    {32'd0, 32'h99},  8'd0,          2'b01, {5'd0, 5'd0},    {4'd0, 4'd7},  0, 2'b11, 8'd0,          {32'd0, 32'h55}, 2'b11, 8'd0,          64'd0,           6'd0};
      vt[17] = '{1, {5'd11, 5'd0},  {5'd0, 5'd0},   2'b00, 10'd0,           64'd0,            8'd0,          2'b00, 10'd0,           8'd0,          0, 2'b11, 8'd0,          64'd0,           2'b11, 8'd0,          64'd0,           6'd0};

      idle_inputs();
      rs1 = {5'd4, 5'd5}; rs2 = {5'd7, 5'd0};
      rst_n = 1'b0;
      #1;
      chk("reset rj", 64'(rj), 64'd3);
      chk("reset rk", 64'(rk), 64'd3);
      chk("reset vj", vj, 64'd0);
      chk("reset cnt", 64'(busy_cnt), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         rdy = vt[i].rdy; rs1 = vt[i].rs1; rs2 = vt[i].rs2;
         commit_valid = vt[i].cv; commit_regid = vt[i].creg;
         commit_value = vt[i].cval; commit_robid = vt[i].crob;
         rename_valid = vt[i].rv; rename_regid = vt[i].rreg; rename_robid = vt[i].rrob;
         pred_fail_flag = vt[i].flush;
         #1;
         check_vec(i, vt[i]);
      end

      // Asynchronous reset between edges wipes busy and value state at once.
      @(negedge clk);
      idle_inputs();
      rename_valid = 2'b01; rename_regid = {5'd0, 5'd3}; rename_robid = {4'd0, 4'd2};
      @(negedge clk);
      idle_inputs();
      rs1 = {5'd0, 5'd3}; rs2 = {5'd0, 5'd5};
      #1;
      chk("pre-rst rj0", 64'(rj[0]), 64'd0);
      chk("pre-rst qj0", 64'(qj[3:0]), 64'd2);
      chk("pre-rst vk0", 64'(vk[31:0]), 64'(DB));
      chk("pre-rst cnt", 64'(busy_cnt), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("async rj0", 64'(rj[0]), 64'd1);
      chk("async vk0", 64'(vk[31:0]), 64'd0);
      chk("async cnt", 64'(busy_cnt), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("post-rst rj", 64'(rj), 64'd3);
      chk("post-rst vj0", 64'(vj[31:0]), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
